// File: rtl/flash_op_seq.sv
// Flash operation sequencer: splits erase/read/write requests into page- or
// sector-bounded ops and hands them one at a time to the flash controller.
module flash_op_seq #(
  parameter int P_PAGE_BYTES   = 256,
  parameter int P_SECTOR_BYTES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req_typ,
  input  logic [23:0] i_req_addr,
  input  logic [15:0] i_req_len,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_op_cnt,
  output logic [1:0]  o_op_typ,
  output logic [23:0] o_op_addr,
  output logic [8:0]  o_op_num,
  output logic        o_op_valid,
  input  logic        i_op_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CALC, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  localparam logic [1:0]  TYP_ERASE = 2'd0;
  localparam logic [1:0]  TYP_BAD   = 2'd3;
  localparam logic [24:0] PAGE_SZ   = 25'(P_PAGE_BYTES);
  localparam logic [24:0] SECT_SZ   = 25'(P_SECTOR_BYTES);
  localparam logic [23:0] SECT_MASK = 24'(P_SECTOR_BYTES - 1);
  localparam logic [24:0] ADDR_LIM  = 25'h100_0000;

  state_t      state, state_n;
  logic [1:0]  typ_q, typ_n;
  logic [23:0] addr_q, addr_n;
  logic [15:0] rem_q, rem_n;
  logic [15:0] chunk_q, chunk_n;
  logic        wfirst_q, wfirst_n;
  logic [7:0]  cnt_n;
  logic [1:0]  op_typ_n;
  logic [23:0] op_addr_n;
  logic [8:0]  op_num_n;
  logic        err_n;

  // Chunk geometry: distance from addr to the next page/sector boundary
  logic [24:0] gran, offs, space, sum_end;
  always_comb begin
    gran    = (typ_q == TYP_ERASE) ? SECT_SZ : PAGE_SZ;
    offs    = {1'b0, addr_q} & (gran - 25'd1);
    space   = gran - offs;
    sum_end = {1'b0, addr_q} + {9'd0, rem_q};
  end

  always_comb begin
    state_n   = state;
    typ_n     = typ_q;
    addr_n    = addr_q;
    rem_n     = rem_q;
    chunk_n   = chunk_q;
    wfirst_n  = 1'b0;
    cnt_n     = o_op_cnt;
    op_typ_n  = o_op_typ;
    op_addr_n = o_op_addr;
    op_num_n  = o_op_num;
    err_n     = o_err;
    case (state)
      S_IDLE: begin
        if (i_req_valid && o_req_ready) begin
          typ_n   = i_req_typ;
          addr_n  = i_req_addr;
          rem_n   = i_req_len;
          cnt_n   = 8'd0;
          err_n   = 1'b0;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (typ_q == TYP_BAD || (typ_q != TYP_ERASE && sum_end > ADDR_LIM)) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else if (rem_q == 16'd0) begin
          state_n = S_DONE;
        end else begin
          state_n = S_CALC;
        end
      end
      S_CALC: begin
        chunk_n  = ({9'd0, rem_q} < space) ? rem_q : space[15:0];
        op_typ_n = typ_q;
        if (typ_q == TYP_ERASE) begin
          op_addr_n = addr_q & ~SECT_MASK;
          op_num_n  = 9'd0;
        end else begin
          op_addr_n = addr_q;
          op_num_n  = chunk_n[8:0];
        end
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_op_ready) begin
          addr_n   = addr_q + {8'd0, chunk_q};
          rem_n    = rem_q - chunk_q;
          cnt_n    = (o_op_cnt == 8'hFF) ? o_op_cnt : o_op_cnt + 8'd1;
          wfirst_n = 1'b1;
          state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Controller ready may still be high from the handshake cycle
        if (!wfirst_q && i_op_ready)
          state_n = (rem_q != 16'd0) ? S_CALC : S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      typ_q       <= 2'd0;
      addr_q      <= 24'd0;
      rem_q       <= 16'd0;
      chunk_q     <= 16'd0;
      wfirst_q    <= 1'b0;
      o_req_ready <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_op_cnt    <= 8'd0;
      o_op_typ    <= 2'd0;
      o_op_addr   <= 24'd0;
      o_op_num    <= 9'd0;
      o_op_valid  <= 1'b0;
    end else begin
      state       <= state_n;
      typ_q       <= typ_n;
      addr_q      <= addr_n;
      rem_q       <= rem_n;
      chunk_q     <= chunk_n;
      wfirst_q    <= wfirst_n;
      o_req_ready <= (state_n == S_IDLE);
      o_done      <= (state_n == S_DONE);
      o_err       <= err_n;
      o_op_cnt    <= cnt_n;
      o_op_typ    <= op_typ_n;
      o_op_addr   <= op_addr_n;
      o_op_num    <= op_num_n;
      o_op_valid  <= (state_n == S_ISSUE);
    end
  end

endmodule
